wb_stage: RTL

//  Writeback stage: consumer of the execute-stage result (rd_data) and the

---
 rtl/wb_stage_if.sv | 41 ++++
 rtl/wb_stage.sv | 106 ++++++++++
 2 files changed

// File: rtl/wb_stage_if.sv
// Writeback stage bus: execute-side result handshake, hold control,
// two register-file read ports and the retirement (commit) report.
// The master side is the surrounding pipeline; the slave side is wb_stage.
interface wb_stage_if #(
   parameter int XLEN = 64
);
   // execute -> writeback result handshake
   logic            ex_valid;
   logic            ex_ready;
   logic            ex_rd_wena;
   logic [4:0]      ex_rd_addr;
   logic [XLEN-1:0] ex_rd_data;
   logic [XLEN-1:0] ex_pc;
   // pipeline freeze
   logic            hold;
   // operand read ports
   logic [4:0]      r1_addr;
   logic [XLEN-1:0] r1_data;
   logic [4:0]      r2_addr;
   logic [XLEN-1:0] r2_data;
   // retirement report
   logic            cmt_valid;
   logic            cmt_rd_wena;
   logic [4:0]      cmt_rd_addr;
   logic [XLEN-1:0] cmt_rd_data;
   logic [XLEN-1:0] cmt_pc;

   modport master (
      output ex_valid, ex_rd_wena, ex_rd_addr, ex_rd_data, ex_pc, hold,
             r1_addr, r2_addr,
      input  ex_ready, r1_data, r2_data,
             cmt_valid, cmt_rd_wena, cmt_rd_addr, cmt_rd_data, cmt_pc
   );

   modport slave (
      input  ex_valid, ex_rd_wena, ex_rd_addr, ex_rd_data, ex_pc, hold,
             r1_addr, r2_addr,
      output ex_ready, r1_data, r2_data,
             cmt_valid, cmt_rd_wena, cmt_rd_addr, cmt_rd_data, cmt_pc
   );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: registers one execute result per cycle, commits it to a
// 32 x XLEN register file on the following edge and bypasses the pending
// result to both read ports. x0 reads as zero and is never written.
// Optional feature: define WB_INSTRET_EN to add a 64-bit retired-instruction
// counter output (instret).
module wb_stage #(
   parameter int XLEN = 64,
   parameter int NREG = 32
) (
   input  logic        clk,
   input  logic        rst,
   wb_stage_if.slave   bus
`ifdef WB_INSTRET_EN
   ,
   output logic [63:0] instret
`endif
);

   logic            pipe_valid;
   logic            pipe_wena;
   logic [4:0]      pipe_addr;
   logic [XLEN-1:0] pipe_data;
   logic [XLEN-1:0] pipe_pc;

   logic [XLEN-1:0] rf [NREG];

   logic accept;
   logic commit;
   logic rf_we;
   logic byp1;
   logic byp2;

   // handshake, commit qualification and bypass hit detection
   always_comb begin
      bus.ex_ready = ~bus.hold;
      accept       = bus.ex_valid & ~bus.hold;
      // a result pending while reset is asserted is dropped, never reported
      commit       = pipe_valid & ~bus.hold & ~rst;
      rf_we        = commit & pipe_wena & (pipe_addr != 5'd0);
      byp1         = pipe_valid & pipe_wena & (bus.r1_addr == pipe_addr);
      byp2         = pipe_valid & pipe_wena & (bus.r2_addr == pipe_addr);
   end

   // commit report comes straight from the pipe register
   always_comb begin
      bus.cmt_valid   = commit;
      bus.cmt_rd_wena = pipe_wena & (pipe_addr != 5'd0);
      bus.cmt_rd_addr = pipe_addr;
      bus.cmt_rd_data = pipe_data;
      bus.cmt_pc      = pipe_pc;
   end

   // read ports: x0 is zero, pending result wins over RF (also under hold)
   always_comb begin
      bus.r1_data = rf[bus.r1_addr];
      if (bus.r1_addr == 5'd0)
         bus.r1_data = '0;
      else if (byp1)
         bus.r1_data = pipe_data;
      bus.r2_data = rf[bus.r2_addr];
      if (bus.r2_addr == 5'd0)
         bus.r2_data = '0;
      else if (byp2)
         bus.r2_data = pipe_data;
   end

   // pipe register: frozen under hold, otherwise loads or empties each cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_valid <= 1'b0;
         pipe_wena  <= 1'b0;
         pipe_addr  <= '0;
         pipe_data  <= '0;
         pipe_pc    <= '0;
      end else if (!bus.hold) begin
         pipe_valid <= accept;
         if (accept) begin
            pipe_wena <= bus.ex_rd_wena;
            pipe_addr <= bus.ex_rd_addr;
            pipe_data <= bus.ex_rd_data;
            pipe_pc   <= bus.ex_pc;
         end
      end
   end

   // register file: cleared by reset, written on commit of a non-x0 rd
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++)
            rf[i] <= '0;
      end else if (rf_we) begin
         rf[pipe_addr] <= pipe_data;
      end
   end

`ifdef WB_INSTRET_EN
   // retired-instruction counter, counts x0 writes too, wraps naturally
   always_ff @(posedge clk) begin
      if (rst)
         instret <= '0;
      else if (commit)
         instret <= instret + 64'd1;
   end
`endif

endmodule
